// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
// Module   : seq_div
// Purpose  : Sequential restoring divider, one iteration per dividend bit.
//            Define SEQ_DIV_ZERO_CHECK_EN to short-circuit a zero divisor.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          locked,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          done_flag,
  output logic          div_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dvs;
  logic [VW-1:0] r_p;
  logic [CW-1:0] r_cnt;
  logic          r_locked;
  logic          r_done;
  logic [DW-1:0] r_quotient;
  logic [VW-1:0] r_remainder;

  logic [VW:0]   w_shift;
  logic          w_ge;
  logic [VW-1:0] w_p_next;
  logic [DW-1:0] w_q_next;

  // The partial remainder is always below the divisor between steps, so its
  // top bit only exists transiently in the shifted value used for compare.
  always_comb begin
    w_shift  = {r_p, r_dvd[DW-1]};
    w_ge     = (w_shift >= {1'b0, r_dvs});
    w_p_next = w_ge ? (w_shift[VW-1:0] - r_dvs) : w_shift[VW-1:0];
    w_q_next = {r_dvd[DW-2:0], w_ge};
  end

`ifdef SEQ_DIV_ZERO_CHECK_EN
  logic r_div_zero;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_locked    <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
      r_div_zero  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd    <= dividend;
            r_dvs    <= divisor;
            r_p      <= '0;
            r_cnt    <= '0;
            r_locked <= 1'b1;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            if (divisor == '0) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= dividend[VW-1:0];
              r_div_zero  <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
`else
            r_state <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          // Quotient bits enter the dividend register as its MSBs leave.
          r_p   <= w_p_next;
          r_dvd <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_quotient  <= w_q_next;
            r_remainder <= w_p_next;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            r_div_zero  <= 1'b0;
`endif
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_done   <= 1'b0;
          r_locked <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_done   <= 1'b0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign locked    = r_locked;
  assign done_flag = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
`ifdef SEQ_DIV_ZERO_CHECK_EN
  assign div_zero  = r_div_zero;
`else
  assign div_zero  = 1'b0;
`endif

endmodule
`default_nettype wire
